// File: rtl/vit_layer_scheduler.sv
// Runs one shared encoder block through up to NUM_LAYERS stacked passes, feeding each result back as the next input.
// Optional per-layer watchdog: define VIT_SCHED_TIMEOUT_EN.
module vit_layer_scheduler #(
  parameter int DATA_WIDTH  = 16,
  parameter int SEQ_LEN     = 8,
  parameter int EMB_DIM     = 8,
  parameter int NUM_LAYERS  = 4,
  parameter int TIMEOUT_CYC = 4096,
  localparam int LW = $clog2(NUM_LAYERS),
  localparam int M  = DATA_WIDTH * SEQ_LEN * EMB_DIM
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [LW:0]   layers_cfg,
  input  logic [M-1:0]  x_in,
  output logic          blk_start,
  input  logic          blk_done,
  output logic [M-1:0]  blk_x_in,
  input  logic [M-1:0]  blk_out,
  output logic [LW-1:0] layer_idx,
  output logic          busy,
  output logic          done,
  output logic [M-1:0]  y_out,
  output logic          err
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_KICK, S_WAIT, S_NEXT, S_DONE} state_t;

  localparam logic [LW:0] NL = (LW+1)'(NUM_LAYERS);

  state_t      state, nxt;
  logic [M-1:0] act;
  logic [LW:0] n_lyr;
  logic        last;
  logic        tmo;

  assign last      = ({1'b0, layer_idx} == n_lyr - 1'b1);
  assign blk_start = (state == S_KICK);
  assign done      = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign blk_x_in  = act;

`ifdef VIT_SCHED_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  logic [WW-1:0] wdog;

  assign tmo = (wdog == WW'(TIMEOUT_CYC - 1));

  // Counts WAIT cycles with no completion; a late blk_done still wins on the limit cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog <= '0;
      err  <= 1'b0;
    end else begin
      if (state == S_KICK)
        wdog <= '0;
      else if (state == S_WAIT && !blk_done)
        wdog <= wdog + 1'b1;
      if (state == S_IDLE && start)
        err <= 1'b0;
      else if (state == S_WAIT && !blk_done && tmo)
        err <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (start) nxt = S_LOAD;
      S_LOAD: nxt = (n_lyr == '0) ? S_DONE : S_KICK;
      S_KICK: nxt = S_WAIT;
      S_WAIT: begin
        if (blk_done) nxt = S_NEXT;
        else if (tmo) nxt = S_DONE;
      end
      S_NEXT: nxt = last ? S_DONE : S_KICK;
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act       <= '0;
      n_lyr     <= '0;
      layer_idx <= '0;
      y_out     <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        act   <= x_in;
        n_lyr <= (layers_cfg > NL) ? NL : layers_cfg;
      end
      if (state == S_WAIT && blk_done)
        act <= blk_out;
      if (state == S_LOAD)
        layer_idx <= '0;
      if (state == S_NEXT && !last)
        layer_idx <= layer_idx + 1'b1;
      // act already holds the last completed layer on every path into DONE
      if (nxt == S_DONE)
        y_out <= act;
    end
  end

endmodule
